// File: rtl/branch_fetch_ctrl.sv
// Fetch PC sequencing with BHT/BTB prediction, IF/ID capture and decode-stage misprediction recovery.
// Define BRANCH_STATS_EN to enable the saturating branch_count / mispredict_count registers.
module branch_fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        halt,
   input  logic        bht_taken,
   input  logic [1:0]  bht_prediction,
   input  logic [15:0] btb_target,
   input  logic        id_is_branch,
   input  logic        id_actual_taken,
   input  logic [15:0] id_actual_target,
   output logic [15:0] PC_curr,
   output logic [15:0] IF_ID_PC_curr,
   output logic [1:0]  IF_ID_prediction,
   output logic        IF_ID_pred_taken,
   output logic [15:0] IF_ID_pred_target,
   output logic        IF_ID_valid,
   output logic        bht_wen,
   output logic        bht_enable,
   output logic        flush,
   output logic [15:0] branch_count,
   output logic [15:0] mispredict_count
);

   logic [15:0] pc_p0;
   logic [15:0] if_id_pc_p1;
   logic [1:0]  if_id_pred_p1;
   logic        if_id_taken_p1;
   logic [15:0] if_id_target_p1;
   logic        vld_p1;

   logic [15:0] pc_plus2;
   logic [15:0] id_plus2;
   logic [15:0] redirect;
   logic        resolve;
   logic        br_resolve;
   logic        mispredict;

   always_comb begin
      pc_plus2   = pc_p0 + 16'd2;
      id_plus2   = if_id_pc_p1 + 16'd2;
      resolve    = vld_p1 & ~stall;
      br_resolve = resolve & id_is_branch;
      mispredict = resolve & (
                     (id_is_branch & (id_actual_taken != if_id_taken_p1)) |
                     (id_is_branch & id_actual_taken & if_id_taken_p1 &
                      (id_actual_target != if_id_target_p1)) |
                     (~id_is_branch & if_id_taken_p1));
      redirect   = (id_is_branch & id_actual_taken) ? id_actual_target : id_plus2;
   end

   // Stage 0: fetch PC; a resolved mispredict overrides stall and halt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_p0 <= RESET_PC;
      end else if (mispredict) begin
         pc_p0 <= redirect;
      end else if (!(stall || halt)) begin
         pc_p0 <= bht_taken ? btb_target : pc_plus2;
      end
   end

   // Stage 1: IF/ID register; the squashed wrong-path slot is cleared to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_pc_p1     <= 16'h0000;
         if_id_pred_p1   <= 2'b00;
         if_id_taken_p1  <= 1'b0;
         if_id_target_p1 <= 16'h0000;
         vld_p1          <= 1'b0;
      end else if (mispredict || (!stall && halt)) begin
         if_id_pc_p1     <= 16'h0000;
         if_id_pred_p1   <= 2'b00;
         if_id_taken_p1  <= 1'b0;
         if_id_target_p1 <= 16'h0000;
         vld_p1          <= 1'b0;
      end else if (!stall) begin
         if_id_pc_p1     <= pc_p0;
         if_id_pred_p1   <= bht_prediction;
         if_id_taken_p1  <= bht_taken;
         if_id_target_p1 <= bht_taken ? btb_target : pc_plus2;
         vld_p1          <= 1'b1;
      end
   end

`ifdef BRANCH_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] br_cnt_p1;
   logic [15:0] mp_cnt_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_p1 <= 16'h0000;
         mp_cnt_p1 <= 16'h0000;
      end else begin
         if (br_resolve) br_cnt_p1 <= sat_inc(br_cnt_p1);
         if (mispredict) mp_cnt_p1 <= sat_inc(mp_cnt_p1);
      end
   end

   assign branch_count     = br_cnt_p1;
   assign mispredict_count = mp_cnt_p1;
`else
   assign branch_count     = 16'h0000;
   assign mispredict_count = 16'h0000;
`endif

   assign PC_curr           = pc_p0;
   assign IF_ID_PC_curr     = if_id_pc_p1;
   assign IF_ID_prediction  = if_id_pred_p1;
   assign IF_ID_pred_taken  = if_id_taken_p1;
   assign IF_ID_pred_target = if_id_target_p1;
   assign IF_ID_valid       = vld_p1;
   assign bht_wen           = br_resolve;
   assign bht_enable        = ~stall;
   assign flush             = mispredict;

endmodule

// File: doc/branch_fetch_ctrl.md
BRANCH_FETCH_CTRL -- requirements
Module: branch_fetch_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  system clock, all state rising-edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: stall  input  1  hazard stall; freezes PC and IF/ID.
REQ-005 SHALL have port: halt  input  1  fetched instruction is HLT; hold PC.
REQ-006 SHALL have ports: bht_taken  input  1, bht_prediction  input  2, btb_target  input  16  (lookup results for PC_curr).
REQ-007 SHALL have ports: id_is_branch  input  1, id_actual_taken  input  1, id_actual_target  input  16  (decode resolution of IF/ID instruction).
REQ-008 SHALL have port: PC_curr  output  16  current fetch PC.
REQ-009 SHALL have ports: IF_ID_PC_curr  output  16, IF_ID_prediction  output  2, IF_ID_pred_taken  output  1, IF_ID_pred_target  output  16, IF_ID_valid  output  1.
REQ-010 SHALL have ports: bht_wen  output  1, bht_enable  output  1, flush  output  1.
REQ-011 SHALL have ports: branch_count  output  16, mispredict_count  output  16.

Function
REQ-012 SHALL define pc_plus2 = PC_curr + 2 and id_plus2 = IF_ID_PC_curr + 2, both modulo 2^16 (0xFFFE + 2 = 0x0000).
REQ-013 SHALL define resolve = IF_ID_valid & ~stall.
REQ-014 SHALL assert mispredict (combinational) when resolve and either: id_is_branch & (id_actual_taken != IF_ID_pred_taken); or id_is_branch & id_actual_taken & IF_ID_pred_taken & (id_actual_target != IF_ID_pred_target); or ~id_is_branch & IF_ID_pred_taken.
REQ-015 SHALL drive flush = mispredict.
REQ-016 SHALL drive redirect = (id_is_branch & id_actual_taken) ? id_actual_target : id_plus2.
REQ-017 SHALL load PC_curr on each clock with priority: mispredict -> redirect; stall -> hold; halt -> hold; bht_taken -> btb_target; else pc_plus2.
REQ-018 SHALL capture IF/ID on each clock with priority: mispredict -> IF_ID_valid=0 and all IF/ID fields 0; stall -> hold all; halt -> IF_ID_valid=0 and fields 0; else IF_ID_PC_curr=PC_curr, IF_ID_prediction=bht_prediction, IF_ID_pred_taken=bht_taken, IF_ID_pred_target=(bht_taken ? btb_target : pc_plus2), IF_ID_valid=1.
REQ-019 SHALL make redirected PC visible on PC_curr exactly one cycle after mispredict assertion; one wrong-path slot is squashed.
REQ-020 SHALL drive bht_wen = resolve & id_is_branch (every resolved branch trains, correct or not).
REQ-021 SHALL drive bht_enable = ~stall.
REQ-022 SHALL give mispredict priority over halt when both occur (halt on wrong path is discarded).
REQ-023 SHALL defer resolution while stall=1: no flush, no bht_wen, no redirect until stall drops.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force PC_curr=RESET_PC, all IF/ID fields=0, IF_ID_valid=0, counters=0.
REQ-025 SHALL keep flush and bht_wen low during reset, since IF_ID_valid=0.
REQ-026 SHALL, on reset assertion mid-redirect, discard the pending redirect; first fetch after release is RESET_PC.

Configuration
REQ-027 SHALL, when BRANCH_STATS_EN is defined, increment branch_count on each cycle with resolve & id_is_branch, and mispredict_count on each cycle with mispredict; both saturate at 16'hFFFF.
REQ-028 SHALL, when BRANCH_STATS_EN is undefined, retain both ports tied to 16'h0000 with no counter registers.

Verification
REQ-029 SHALL cover: reset release, bht_taken=0 for 3 cycles -> PC_curr 0x0000, 0x0002, 0x0004, 0x0006; IF_ID_valid=1 from cycle 2.
REQ-030 SHALL cover: PC_curr=0x0010, bht_taken=1, btb_target=0x0040, next cycle id_is_branch=1, id_actual_taken=1, id_actual_target=0x0040 -> no flush, bht_wen=1, PC_curr continues 0x0040, 0x0042.
REQ-031 SHALL cover: PC_curr=0x0020 predicted not-taken, resolved taken to 0x0100 -> flush=1 one cycle, IF_ID_valid=0 next cycle, PC_curr=0x0100 next cycle, mispredict_count=1 when BRANCH_STATS_EN is defined.
REQ-032 SHALL cover: non-branch at 0x0030 predicted taken to 0x0080 -> flush=1, bht_wen=0, PC_curr=0x0032.
REQ-033 SHALL cover: mispredict condition present with stall=1 for 2 cycles -> flush=0 and PC/IF_ID held during stall; flush=1 in the cycle stall drops.
REQ-034 SHALL cover: PC_curr=0xFFFE, no prediction -> next PC_curr=0x0000; halt=1 -> PC_curr held, IF_ID_valid=0.
